// File: rtl/zube_mailbox_ctrl.sv
// zube_mailbox_ctrl: SoC-side controller for the Zube Z80 mailbox.
// Grants one of two SoC requesters (CPU = 0, DMA = 1) at a time, in
// round-robin order, access to the Data IN / Data OUT registers. It also
// keeps the full/empty/overrun flags, publishes the Status In byte to the
// Z80, and raises irq while Data OUT holds an unread byte.
module zube_mailbox_ctrl #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        z80_data_out_wr,
  input  logic        z80_data_in_rd,
  input  logic [7:0]  data_out_contents,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ack,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        data_in_we,
  output logic [7:0]  data_in_wdata,
  output logic        status_in_we,
  output logic [7:0]  status_in_byte,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Last counter value before a waiting transfer gives up with an error.
  localparam logic [15:0] C_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic        r_last_grant;
  logic        r_winner;
  logic        r_op_write;
  logic [7:0]  r_wbyte;
  logic [15:0] r_cnt;
  logic        r_data_in_full;
  logic        r_data_out_full;
  logic        r_overrun;
  logic [1:0]  r_req_ack;
  logic [7:0]  r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_data_in_we;
  logic [7:0]  r_data_in_wdata;
  logic        r_status_in_we;
  logic [7:0]  r_status_in_byte;

  logic        w_wr_done;
  logic        w_rd_done;
  logic        w_timeout;
  logic        w_pick;
  logic        w_dif_nxt;
  logic        w_dof_nxt;
  logic        w_ovr_nxt;
  logic [7:0]  w_status_nxt;

  // Completion conditions for the transfer currently being served.
  always_comb begin
    w_wr_done = (r_state == ST_SERVE) && r_op_write && !r_data_in_full;
    w_rd_done = (r_state == ST_SERVE) && !r_op_write && r_data_out_full;
    w_timeout = (r_state == ST_SERVE) && !w_wr_done && !w_rd_done && (r_cnt == C_LAST);
  end

  // Round-robin pick: on a tie the requester that was not granted last wins.
  always_comb begin
    w_pick = 1'b0;
    if (req_valid == 2'b11) begin
      w_pick = ~r_last_grant;
    end else if (req_valid[1]) begin
      w_pick = 1'b1;
    end else begin
      w_pick = 1'b0;
    end
  end

  // Next flag values. A Z80 event and a SoC completion in the same cycle
  // resolve so that the newest byte is always treated as present.
  always_comb begin
    w_dif_nxt = r_data_in_full;
    w_dof_nxt = r_data_out_full;
    w_ovr_nxt = r_overrun;
    if (w_wr_done) begin
      w_dif_nxt = 1'b1;
    end else if (z80_data_in_rd) begin
      w_dif_nxt = 1'b0;
    end else begin
      w_dif_nxt = r_data_in_full;
    end
    if (z80_data_out_wr) begin
      w_dof_nxt = 1'b1;
      if (w_rd_done) begin
        w_ovr_nxt = 1'b0;
      end else if (r_data_out_full) begin
        w_ovr_nxt = 1'b1;
      end else begin
        w_ovr_nxt = r_overrun;
      end
    end else if (w_rd_done) begin
      w_dof_nxt = 1'b0;
      w_ovr_nxt = 1'b0;
    end else begin
      w_dof_nxt = r_data_out_full;
      w_ovr_nxt = r_overrun;
    end
    w_status_nxt = {5'b00000, r_overrun, ~r_data_out_full, r_data_in_full};
  end

  // Transfer FSM plus flags and all registered outputs. The status byte
  // follows the flags one cycle later, and its write strobe fires whenever
  // the byte changes, which includes the first cycle after reset.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state          <= ST_IDLE;
      r_last_grant     <= 1'b1;
      r_winner         <= 1'b0;
      r_op_write       <= 1'b0;
      r_wbyte          <= 8'h00;
      r_cnt            <= 16'h0000;
      r_data_in_full   <= 1'b0;
      r_data_out_full  <= 1'b0;
      r_overrun        <= 1'b0;
      r_req_ack        <= 2'b00;
      r_rsp_rdata      <= 8'h00;
      r_rsp_err        <= 1'b0;
      r_data_in_we     <= 1'b0;
      r_data_in_wdata  <= 8'h00;
      r_status_in_we   <= 1'b0;
      r_status_in_byte <= 8'h00;
    end else begin
      r_req_ack        <= 2'b00;
      r_data_in_we     <= 1'b0;
      r_data_in_full   <= w_dif_nxt;
      r_data_out_full  <= w_dof_nxt;
      r_overrun        <= w_ovr_nxt;
      r_status_in_byte <= w_status_nxt;
      r_status_in_we   <= (w_status_nxt != r_status_in_byte);
      case (r_state)
        ST_IDLE: begin
          if (|req_valid) begin
            r_winner   <= w_pick;
            r_op_write <= req_write[w_pick];
            r_wbyte    <= w_pick ? req_wdata[15:8] : req_wdata[7:0];
            r_cnt      <= 16'h0000;
            r_state    <= ST_SERVE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SERVE: begin
          if (w_wr_done) begin
            r_data_in_we    <= 1'b1;
            r_data_in_wdata <= r_wbyte;
            r_rsp_rdata     <= 8'h00;
            r_rsp_err       <= 1'b0;
            r_req_ack       <= r_winner ? 2'b10 : 2'b01;
            r_state         <= ST_DONE;
          end else if (w_rd_done) begin
            r_rsp_rdata <= data_out_contents;
            r_rsp_err   <= 1'b0;
            r_req_ack   <= r_winner ? 2'b10 : 2'b01;
            r_state     <= ST_DONE;
          end else if (w_timeout) begin
            r_rsp_rdata <= 8'h00;
            r_rsp_err   <= 1'b1;
            r_req_ack   <= r_winner ? 2'b10 : 2'b01;
            r_state     <= ST_DONE;
          end else begin
            r_cnt   <= r_cnt + 16'h0001;
            r_state <= ST_SERVE;
          end
        end
        ST_DONE: begin
          r_last_grant <= r_winner;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack        = r_req_ack;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_err        = r_rsp_err;
  assign data_in_we     = r_data_in_we;
  assign data_in_wdata  = r_data_in_wdata;
  assign status_in_we   = r_status_in_we;
  assign status_in_byte = r_status_in_byte;
  assign irq            = r_data_out_full;

endmodule

// File: tb/tb_zube_mailbox_ctrl.sv
// Directed bench for zube_mailbox_ctrl with hand-computed expectations.
module tb_zube_mailbox_ctrl;

  logic        clk;
  logic        reset_b;
  logic        z80_data_out_wr;
  logic        z80_data_in_rd;
  logic [7:0]  data_out_contents;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [15:0] req_wdata;
  logic [1:0]  req_ack;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        data_in_we;
  logic [7:0]  data_in_wdata;
  logic        status_in_we;
  logic [7:0]  status_in_byte;
  logic        irq;

  int n_checks;
  int n_fail;

  zube_mailbox_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk               (clk),
    .reset_b           (reset_b),
    .z80_data_out_wr   (z80_data_out_wr),
    .z80_data_in_rd    (z80_data_in_rd),
    .data_out_contents (data_out_contents),
    .req_valid         (req_valid),
    .req_write         (req_write),
    .req_wdata         (req_wdata),
    .req_ack           (req_ack),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .data_in_we        (data_in_we),
    .data_in_wdata     (data_in_wdata),
    .status_in_we      (status_in_we),
    .status_in_byte    (status_in_byte),
    .irq               (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it and report any mismatch.
  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          n_we;
  int          n_ack;
  int          n_bad;
  logic [7:0]  last_byte;
  logic [1:0]  acks [4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_b           = 1'b0;
    z80_data_out_wr   = 1'b0;
    z80_data_in_rd    = 1'b0;
    data_out_contents = 8'h00;
    req_valid         = 2'b00;
    req_write         = 2'b00;
    req_wdata         = 16'h0000;
    repeat (3) tick();
    check_val("rst_ack", {30'd0, req_ack}, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    check_val("rst_stat_we", {31'd0, status_in_we}, 32'd0);

    // 1: one status pulse with 0x02 after reset release
    reset_b = 1'b1;
    n_we = 0;
    last_byte = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (status_in_we) begin
        n_we++;
        last_byte = status_in_byte;
      end
    end
    check_val("t1_we_count", n_we, 32'd1);
    check_val("t1_byte", {24'd0, last_byte}, 32'h02);
    check_val("t1_irq", {31'd0, irq}, 32'd0);
    check_val("t1_ack", {30'd0, req_ack}, 32'd0);

    // 2: req0 writes 0xA5
    req_valid = 2'b01; req_write = 2'b01; req_wdata = 16'h00A5;
    tick();
    check_val("t2_we_early", {31'd0, data_in_we}, 32'd0);
    tick();
    check_val("t2_we", {31'd0, data_in_we}, 32'd1);
    check_val("t2_wdata", {24'd0, data_in_wdata}, 32'hA5);
    check_val("t2_ack", {30'd0, req_ack}, 32'h1);
    check_val("t2_err", {31'd0, rsp_err}, 32'd0);
    req_valid = 2'b00;
    tick();
    check_val("t2_ack_once", {30'd0, req_ack}, 32'd0);
    check_val("t2_stat", {24'd0, status_in_byte}, 32'h03);
    check_val("t2_stat_we", {31'd0, status_in_we}, 32'd1);
    z80_data_in_rd = 1'b1;
    tick();
    z80_data_in_rd = 1'b0;
    tick();
    check_val("t2_stat_rd", {24'd0, status_in_byte}, 32'h02);
    check_val("t2_stat_rd_we", {31'd0, status_in_we}, 32'd1);

    // 3: Z80 posts 0x3C, req1 reads it
    data_out_contents = 8'h3C;
    z80_data_out_wr = 1'b1;
    tick();
    z80_data_out_wr = 1'b0;
    check_val("t3_irq_set", {31'd0, irq}, 32'd1);
    tick();
    check_val("t3_stat", {24'd0, status_in_byte}, 32'h00);
    req_valid = 2'b10; req_write = 2'b00;
    tick();
    tick();
    check_val("t3_ack", {30'd0, req_ack}, 32'h2);
    check_val("t3_rdata", {24'd0, rsp_rdata}, 32'h3C);
    check_val("t3_err", {31'd0, rsp_err}, 32'd0);
    check_val("t3_irq_clr", {31'd0, irq}, 32'd0);
    req_valid = 2'b00;
    tick();
    check_val("t3_stat_after", {24'd0, status_in_byte}, 32'h02);
    check_val("t3_rdata_hold", {24'd0, rsp_rdata}, 32'h3C);

    // 4: both requesters read continuously, Data OUT kept full
    data_out_contents = 8'h5A;
    req_valid = 2'b11; req_write = 2'b00; z80_data_out_wr = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 20 && n_ack < 4; i++) begin
      tick();
      if (req_ack != 2'b00) begin
        acks[n_ack] = req_ack;
        n_ack++;
        if (n_ack == 4) begin
          req_valid = 2'b00;
          z80_data_out_wr = 1'b0;
        end
      end
    end
    req_valid = 2'b00;
    z80_data_out_wr = 1'b0;
    check_val("t4_n_ack", n_ack, 32'd4);
    check_val("t4_ack0", {30'd0, acks[0]}, 32'h1);
    check_val("t4_ack1", {30'd0, acks[1]}, 32'h2);
    check_val("t4_ack2", {30'd0, acks[2]}, 32'h1);
    check_val("t4_ack3", {30'd0, acks[3]}, 32'h2);
    tick();
    check_val("t4_irq_kept", {31'd0, irq}, 32'd1);
    // drain the last byte with a single req0 read
    req_valid = 2'b01;
    tick();
    tick();
    check_val("t4_drain_ack", {30'd0, req_ack}, 32'h1);
    check_val("t4_drain_rdata", {24'd0, rsp_rdata}, 32'h5A);
    req_valid = 2'b00;
    tick();
    tick();
    check_val("t4_stat", {24'd0, status_in_byte}, 32'h02);

    // 5: read timeout with Data OUT empty (TIMEOUT_CYCLES = 4)
    req_valid = 2'b01; req_write = 2'b00;
    n_bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (req_ack != 2'b00 || status_in_we) n_bad++;
    end
    check_val("t5_no_early_ack", n_bad, 32'd0);
    tick();
    check_val("t5_ack", {30'd0, req_ack}, 32'h1);
    check_val("t5_err", {31'd0, rsp_err}, 32'd1);
    check_val("t5_rdata", {24'd0, rsp_rdata}, 32'h00);
    req_valid = 2'b00;
    tick();
    check_val("t5_stat", {24'd0, status_in_byte}, 32'h02);
    check_val("t5_irq", {31'd0, irq}, 32'd0);
    check_val("t5_err_hold", {31'd0, rsp_err}, 32'd1);

    // 6: overrun, then reset during a stalled write
    z80_data_out_wr = 1'b1;
    tick();
    z80_data_out_wr = 1'b0;
    tick();
    z80_data_out_wr = 1'b1;
    tick();
    z80_data_out_wr = 1'b0;
    tick();
    check_val("t6_overrun", {24'd0, status_in_byte}, 32'h04);
    check_val("t6_irq", {31'd0, irq}, 32'd1);
    req_valid = 2'b01; req_write = 2'b01; req_wdata = 16'h0011;
    tick();
    tick();
    check_val("t6_w1_ack", {30'd0, req_ack}, 32'h1);
    req_valid = 2'b00;
    tick();
    req_valid = 2'b10; req_write = 2'b10; req_wdata = 16'h2200;
    tick();
    tick();
    check_val("t6_stall_ack", {30'd0, req_ack}, 32'd0);
    check_val("t6_stall_we", {31'd0, data_in_we}, 32'd0);
    #2;
    reset_b = 1'b0;
    #1;
    check_val("t6_rst_ack", {30'd0, req_ack}, 32'd0);
    check_val("t6_rst_irq", {31'd0, irq}, 32'd0);
    check_val("t6_rst_stat", {24'd0, status_in_byte}, 32'h00);
    check_val("t6_rst_rdata", {24'd0, rsp_rdata}, 32'h00);
    check_val("t6_rst_err", {31'd0, rsp_err}, 32'd0);
    check_val("t6_rst_wdata", {24'd0, data_in_wdata}, 32'h00);
    req_valid = 2'b00;
    tick();
    tick();
    reset_b = 1'b1;
    n_bad = 0;
    n_we = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (req_ack != 2'b00 || data_in_we) n_bad++;
      if (status_in_we) n_we++;
    end
    check_val("t6_no_ack", n_bad, 32'd0);
    check_val("t6_stat_pulse", n_we, 32'd1);
    check_val("t6_stat_byte", {24'd0, status_in_byte}, 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
